serial_bit_tx: RTL
==================

// Module: serial_bit_tx
// PURPOSE
//  Parallel-to-serial transmitter that drives the 1-bit serial line sampled by the
//  team's single-bit registered receiver DUTs.
//  Accepts a DATA_W word on a valid/ready handshake, then emits a framed bit stream
//  (start, data LSB-first, optional even parity, stop) with CLKS_PER_BIT clocks per bit.
//  Sits on the driving side of the basic interface: its line_out feeds the DUT's serial input.
// PARAMETERS
//  DATA_W        8   payload bits per frame (>=1)
//  CLKS_PER_BIT  4   clock cycles each serial bit is held (>=1)
//  PARITY_EN     1   1: append even-parity bit after data; 0: no parity bit
//  STOP_BITS     1   number of stop bits (1 or 2), each at level 1
// PORTS
//  clk        input   1       single clock; all state changes on posedge clk
//  rst        input   1       asynchronous, active-high reset
//  tx_data    input   DATA_W  payload word; sampled only on handshake
//  tx_valid   input   1       payload word is valid
//  tx_ready   output  1       block can accept a word this cycle
//  line_out   output  1       serial line; idle level 1
//  busy       output  1       frame in progress (any state other than IDLE)
//  done       output  1       one-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//  - Reset (async, immediate): line_out=1, tx_ready=1, busy=0, done=0, state=IDLE,
//    bit timer=0, shift register=0. Reset mid-frame aborts the frame; no partial stop bit.
//  - States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//  - IDLE: tx_ready=1, line_out=1. Handshake = tx_valid && tx_ready at posedge.
//    On handshake: latch tx_data into the shift register, compute even parity
//    (^tx_data), and enter START. line_out=0 from the next cycle.
//    Later changes to tx_data are ignored until the next handshake.
//  - Each bit state holds line_out for exactly CLKS_PER_BIT cycles. The timer counts
//    0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT) (min 1). bit_end = (timer==CLKS_PER_BIT-1).
//  - DATA: line_out = shreg[0]. On bit_end, shift right and increment the bit index.
//    Leave DATA after DATA_W bits (index == DATA_W-1 at bit_end).
//  - PARITY: line_out = latched parity (payload ones + parity bit = even).
//  - STOP: line_out=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 in the last of these
//    cycles only. Return to IDLE on the next cycle.
//  - tx_ready=0 in every non-IDLE state, including the done cycle.
//    Back-to-back: the earliest next START is 1 cycle of IDLE after STOP.
//  - Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles, plus 1 IDLE
//    cycle between consecutive frames.
//  - Outputs are registered: line_out, busy and done come from flops, not combinational
//    decode of tx_valid.
//  - tx_valid=1 while busy has no effect; the word is held off (not dropped) until
//    tx_ready.
//  - CLKS_PER_BIT=1: every bit lasts one cycle; the timer is constant 0 and bit_end=1.
// STRUCTURE
//  - serial_pkg: typedef enum logic [2:0] {TX_IDLE,TX_START,TX_DATA,TX_PARITY,TX_STOP}
//    tx_state_e; localparam LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
//  - Sub-module bit_timer #(CLKS_PER_BIT) (clk, rst, clear, bit_end): a cycle counter
//    cleared on handshake/state entry. The FSM, shift register and parity stay in
//    serial_bit_tx.
// TESTING
//  1 Reset: assert rst for 3 cycles mid-clock -> line_out=1, tx_ready=1, busy=0, done=0
//    immediately, without waiting for clk.
//  2 Single frame (defaults): send 8'hA5 -> line bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop),
//    each held 4 cycles (44 cycles). done exactly once, in cycle 44.
//  3 Odd parity payload: 8'h07 -> parity bit = 1; PARITY_EN=0 build -> 40-cycle frame,
//    no parity slot.
//  4 Back-to-back: tx_valid held high with 8'h00 then 8'hFF -> second start bit 1 cycle
//    after the first done. tx_ready=0 throughout each frame.
//  5 Reset mid-frame: assert rst during DATA bit 3 of 8'h3C -> line_out=1 at once, done
//    never pulses. After release, a new 8'h81 frame is correct.
//  6 CLKS_PER_BIT=1, STOP_BITS=2: send 8'h5A -> 12-cycle frame, two consecutive 1 stop
//    bits, done in cycle 12. Also change tx_data after handshake -> transmitted bits
//    unaffected.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmitter slice.
package serial_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_end_next
);

    localparam int unsigned   TW   = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        bit_end = (cnt_q == LAST);
        if (clear || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
        // Lets the owner register a last-cycle flag without a decode lag.
        bit_end_next = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial framer: start, data LSB-first, optional even parity, stop bits.
module serial_bit_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              line_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned   IW        = cnt_width(DATA_W);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              timer_clear;
    logic              bit_end;
    logic              bit_end_next;

    assign timer_clear = (state_q == TX_IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (timer_clear),
        .bit_end     (bit_end),
        .bit_end_next(bit_end_next)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        unique case (state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    state_d    = TX_START;
                    shreg_d    = tx_data;
                    parity_d   = ^tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = TX_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Outputs are decoded from the next state so the flops line up with it.
        unique case (state_d)
            TX_START:  line_d = START_LVL;
            TX_DATA:   line_d = shreg_d[0];
            TX_PARITY: line_d = parity_d;
            TX_STOP:   line_d = STOP_LVL;
            default:   line_d = LINE_IDLE;
        endcase

        busy_d  = (state_d != TX_IDLE);
        ready_d = (state_d == TX_IDLE);
        done_d  = (state_d == TX_STOP) && (stop_idx_d == LAST_STOP) && bit_end_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            line_q     <= LINE_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign tx_ready = ready_q;
    assign line_out = line_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
